// File: rtl/ws2812_tx.sv
// ---------------------------------------------------------------------------
// ws2812_tx
//
// This module is a serial transmitter for a WS2812-style single-wire LED chain.
// On a start request it latches the 24-bit colour word {R, G, B} and reorders
// it to GRB. It then sends that word MSB-first to each of the NUM_LEDS LEDs,
// using pulse-width coded bits. After the last bit it holds the line low for
// TRST cycles so that the chain latches the data.
//
// Ports:
//   CLK    in   1  system clock
//   RST    in   1  synchronous, active-low reset
//   color  in  24  colour word {R[23:16], G[15:8], B[7:0]}
//   start  in   1  transmit request, sampled only while idle
//   busy   out  1  high while a frame (bits + latch interval) is in progress
//   done   out  1  one-cycle pulse when a frame completes
//   dout   out  1  registered serial data line to the LED chain
//
// Optional build macro:
//   AUTO_REFRESH_EN  When defined, the block keeps a copy of the last colour
//                    it transmitted. While idle, any difference between the
//                    color input and that copy starts a frame, exactly as a
//                    start request would.
// ---------------------------------------------------------------------------
module ws2812_tx #(
  parameter int T0H      = 20,
  parameter int T1H      = 40,
  parameter int TBIT     = 62,
  parameter int TRST     = 2600,
  parameter int NUM_LEDS = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [23:0] color,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        dout
);

  // One cycle counter serves both the bit period and the latch interval.
  // Its width therefore covers the larger of the two.
  localparam int CMAX = (TRST > TBIT) ? TRST : TBIT;
  localparam int CW   = $clog2(CMAX);
  localparam int LW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [CW-1:0] CYC_BIT_LAST = CW'(TBIT - 1);
  localparam logic [CW-1:0] CYC_RST_LAST = CW'(TRST - 1);
  localparam logic [CW-1:0] HI_ZERO      = CW'(T0H);
  localparam logic [CW-1:0] HI_ONE       = CW'(T1H);
  localparam logic [4:0]    BIT_LAST     = 5'd23;
  localparam logic [LW-1:0] LED_LAST     = LW'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [23:0]    shreg_reg, shreg_next;
  logic [4:0]     bit_idx_reg, bit_idx_next;
  logic [LW-1:0]  led_idx_reg, led_idx_next;
  logic [CW-1:0]  cyc_reg, cyc_next;
  logic           dout_reg, dout_next;
  logic           done_reg, done_next;
  logic           trigger;
  logic           cur_bit;
  logic [CW-1:0]  hi_len;
  logic [23:0]    grb;

  // The LEDs expect green first, so the R and G bytes swap places.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_grb
      assign grb[16 + gi] = color[8 + gi];
      assign grb[8 + gi]  = color[16 + gi];
      assign grb[gi]      = color[gi];
    end
  endgenerate

`ifdef AUTO_REFRESH_EN
  logic [23:0] last_color_reg, last_color_next;
  assign trigger = start | (color != last_color_reg);
`else
  assign trigger = start;
`endif

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg      <= IDLE;
      shreg_reg      <= '0;
      bit_idx_reg    <= '0;
      led_idx_reg    <= '0;
      cyc_reg        <= '0;
      dout_reg       <= 1'b0;
      done_reg       <= 1'b0;
`ifdef AUTO_REFRESH_EN
      last_color_reg <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      shreg_reg      <= shreg_next;
      bit_idx_reg    <= bit_idx_next;
      led_idx_reg    <= led_idx_next;
      cyc_reg        <= cyc_next;
      dout_reg       <= dout_next;
      done_reg       <= done_next;
`ifdef AUTO_REFRESH_EN
      last_color_reg <= last_color_next;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    shreg_next      = shreg_reg;
    bit_idx_next    = bit_idx_reg;
    led_idx_next    = led_idx_reg;
    cyc_next        = cyc_reg;
    done_next       = 1'b0;
`ifdef AUTO_REFRESH_EN
    last_color_next = last_color_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (trigger) begin
          state_next      = SEND;
          shreg_next      = grb;
          bit_idx_next    = '0;
          led_idx_next    = '0;
          cyc_next        = '0;
`ifdef AUTO_REFRESH_EN
          last_color_next = color;
`endif
        end
      end

      SEND: begin
        if (cyc_reg == CYC_BIT_LAST) begin
          cyc_next = '0;
          if (bit_idx_reg == BIT_LAST) begin
            bit_idx_next = '0;
            if (led_idx_reg == LED_LAST) begin
              state_next = LATCH;
            end else begin
              led_idx_next = led_idx_reg + LW'(1);
            end
          end else begin
            bit_idx_next = bit_idx_reg + 5'd1;
          end
        end else begin
          cyc_next = cyc_reg + CW'(1);
        end
      end

      LATCH: begin
        if (cyc_reg == CYC_RST_LAST) begin
          state_next = IDLE;
          cyc_next   = '0;
          done_next  = 1'b1;
        end else begin
          cyc_next = cyc_reg + CW'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // dout is a register. The level it should show next cycle is decoded from
  // the next-state counters. This lets the high phase of bit 0 appear in the
  // very first cycle after the start is accepted.
  assign cur_bit   = shreg_next[BIT_LAST - bit_idx_next];
  assign hi_len    = cur_bit ? HI_ONE : HI_ZERO;
  assign dout_next = (state_next == SEND) && (cyc_next < hi_len);

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign dout = dout_reg;

endmodule

// File: tb/tb_ws2812_tx.sv
// ---------------------------------------------------------------------------
// tb_ws2812_tx
//
// This is the testbench for ws2812_tx.
//
// The stimulus side runs a transaction-level model. For every clock edge it
// decides whether a frame is accepted, which GRB word that frame carries, and
// when the frame should end. When a frame is accepted, its expectation is
// pushed onto a queue.
//
// An independent monitor decodes the dout waveform into bits using the pulse
// widths. When it sees done or an abort, it pops the queue and compares.
// ---------------------------------------------------------------------------
module tb_ws2812_tx;

  localparam int T0H      = 2;
  localparam int T1H      = 4;
  localparam int TBIT     = 6;
  localparam int TRST     = 10;
  localparam int NUM_LEDS = 2;
  localparam int FRAME    = NUM_LEDS * 24 * TBIT + TRST;

`ifdef AUTO_REFRESH_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [23:0] color = '0;
  logic        busy, done, dout;

  ws2812_tx #(
    .T0H      (T0H),
    .T1H      (T1H),
    .TBIT     (TBIT),
    .TRST     (TRST),
    .NUM_LEDS (NUM_LEDS)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .color (color),
    .start (start),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  always #5 CLK = ~CLK;

  // edge_n counts rising edges. After the e-th edge, edge_n holds e.
  int unsigned edge_n   = 0;
  logic        rst_prev = 1'b1;
  always @(posedge CLK) begin
    edge_n   <= edge_n + 1;
    rst_prev <= RST;
  end

  typedef struct {
    logic [23:0] grb;
    int unsigned k;
    bit          abort;
    int unsigned abort_edge;
  } frame_t;

  frame_t      exp_q[$];
  int          vecs = 0;
  int          errs = 0;
  int          nframes = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, got, want, edge_n);
    end
  endtask

  // ---------------- reference model (stimulus side) ----------------
  int unsigned free_edge  = 0;
  logic [23:0] model_last = '0;

  task automatic step(input logic rst_v, input logic st_v, input logic [23:0] col_v);
    int unsigned e;
    frame_t f;
    @(negedge CLK);
    RST   = rst_v;
    start = st_v;
    color = col_v;
    e = edge_n + 1;
    if (!rst_v) begin
      if (e < free_edge && exp_q.size() > 0 && !exp_q[exp_q.size()-1].abort) begin
        exp_q[exp_q.size()-1].abort      = 1'b1;
        exp_q[exp_q.size()-1].abort_edge = e;
      end
      free_edge  = e + 1;
      model_last = '0;
    end else if (e >= free_edge && (st_v || (AUTO && col_v != model_last))) begin
      f.grb        = {col_v[15:8], col_v[23:16], col_v[7:0]};
      f.k          = e;
      f.abort      = 1'b0;
      f.abort_edge = 0;
      exp_q.push_back(f);
      free_edge  = e + FRAME + 1;
      model_last = col_v;
    end
  endtask

  task automatic idle(input int n, input logic [23:0] col_v);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, col_v);
  endtask

  // ---------------- monitor ----------------
  bit in_frame = 1'b0;
  int hi = 0, lo = 0, flen = 0, tbad = 0;
  bit bits_q[$];

  task automatic take_bit(input bit last);
    int want;
    want = last ? TBIT + TRST : TBIT;
    if (!((hi == T0H || hi == T1H) && (hi + lo == want))) tbad++;
    bits_q.push_back(hi == T1H);
    hi = 0;
    lo = 0;
  endtask

  task automatic finish_normal();
    frame_t f;
    logic [23:0] w;
    take_bit(1'b1);
    chk("frame queued at done", 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      f = exp_q.pop_front();
      chk("frame not aborted", 64'(f.abort), 64'd0);
      chk("done edge", 64'(edge_n), 64'(f.k + FRAME));
      chk("busy length", 64'(flen), 64'(FRAME));
      chk("pulse timing errors", 64'(tbad), 64'd0);
      chk("bit count", 64'(bits_q.size()), 64'(NUM_LEDS * 24));
      for (int l = 0; l < NUM_LEDS; l++) begin
        w = '0;
        for (int b = 0; b < 24; b++)
          if (l * 24 + b < bits_q.size()) w = {w[22:0], bits_q[l * 24 + b]};
        chk("led word", 64'(w), 64'(f.grb));
      end
      nframes++;
      $display("frame %0d: start edge %0d, grb %06h, done edge %0d", nframes, f.k, f.grb, edge_n);
    end
  endtask

  task automatic finish_abort();
    frame_t f;
    chk("frame queued at abort", 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      f = exp_q.pop_front();
      chk("abort expected", 64'(f.abort), 64'd1);
      chk("abort edge", 64'(edge_n), 64'(f.abort_edge));
      $display("frame aborted: start edge %0d, grb %06h, reset edge %0d", f.k, f.grb, edge_n);
    end
    chk("dout low after abort", 64'(dout), 64'd0);
  endtask

  always @(negedge CLK) begin
    bit ended;
    ended = 1'b0;
    if (edge_n > 0) begin
      if (in_frame && busy !== 1'b1) begin
        ended    = 1'b1;
        in_frame = 1'b0;
        if (done === 1'b1) finish_normal();
        else finish_abort();
      end else if (in_frame) begin
        flen++;
        if (dout === 1'b1) begin
          if (lo > 0) take_bit(1'b0);
          hi++;
        end else begin
          lo++;
        end
      end
      if (!ended) chk("stray done", 64'(done), 64'd0);
      if (rst_prev === 1'b0) begin
        chk("busy in reset", 64'(busy), 64'd0);
        chk("dout in reset", 64'(dout), 64'd0);
      end
      if (!in_frame && !ended && rst_prev === 1'b1 && busy === 1'b1) begin
        chk("frame queued at start", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) chk("start edge", 64'(edge_n), 64'(exp_q[0].k));
        chk("first bit high", 64'(dout), 64'd1);
        in_frame = 1'b1;
        flen     = 1;
        tbad     = 0;
        hi       = (dout === 1'b1) ? 1 : 0;
        lo       = (dout === 1'b1) ? 0 : 1;
        bits_q.delete();
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [23:0] col;

    // Reset held low with start high: nothing may start.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 24'hFF_00_00);
    idle(2, 24'hFF_00_00);

    // Red frame, with start pulses (and a new colour) that arrive while busy.
    step(1'b1, 1'b1, 24'hFF_00_00);
    idle(49, 24'hFF_00_00);
    step(1'b1, 1'b1, 24'h00_00_FF);
    idle(244, 24'h00_00_FF);
    step(1'b1, 1'b1, 24'h00_00_FF);
    idle(15, 24'h00_00_FF);

    // Bit timing: the first transmitted bit is a '1'.
    step(1'b1, 1'b1, 24'h00_80_00);
    idle(305, 24'h00_80_00);

    // Reset mid-frame, then a clean frame after release.
    step(1'b1, 1'b1, 24'hA5_3C_0F);
    idle(99, 24'hA5_3C_0F);
    step(1'b0, 1'b0, 24'hA5_3C_0F);
    idle(3, 24'hA5_3C_0F);
    step(1'b1, 1'b1, 24'h12_34_56);
    idle(305, 24'h12_34_56);

    // start held continuously: back-to-back frames.
    for (int i = 0; i < 2 * (FRAME + 1) + 3; i++) step(1'b1, 1'b1, 24'h0F_F0_C3);
    idle(305, 24'h0F_F0_C3);

    // Colour change with start low: a frame starts only with auto refresh.
    idle(2, 24'h00_00_00);
    idle(310, 24'h00_00_00);
    idle(310, 24'h55_55_55);

    // Randomized traffic with occasional resets.
    col = 24'($urandom());
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) col = 24'($urandom());
      step(($urandom_range(0, 799) != 0), ($urandom_range(0, 39) == 0), col);
    end
    idle(320, col);

    chk("frames left in scoreboard", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
